rx_frame_parser: RTL and testbench
==================================

RX_FRAME_PARSER -- requirements
Module: rx_frame_parser

Interface
REQ-001 SHALL have parameter DEV_ID, default 16'h0001: the 16-bit bus address this node accepts.
REQ-002 SHALL have parameter DATA_BYTES, default 4 (range 1..16): maximum write payload in bytes.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 10000: idle clocks between bytes before a partial frame is aborted.
REQ-004 SHALL have parameter READ_CODE, default 8'h03: RW byte value meaning read; any other value means write.
REQ-005 SHALL have port sys_clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-006 SHALL have port sys_rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have port rx_flag, input, 1 bit: one-cycle strobe, rx_data valid.
REQ-008 SHALL have port rx_data, input, 8 bits: received byte.
REQ-009 SHALL have port ret_cmd, output, 8 bits: sensor ID to read back.
REQ-010 SHALL have port ret_cmd_flg, output, 1 bit: one-cycle valid pulse for ret_cmd.
REQ-011 SHALL have port sen_cmd, output, 8+8*DATA_BYTES bits: {SID, data}, data byte 0 in [7:0].
REQ-012 SHALL have port sen_cmd_len, output, 5 bits: number of valid data bytes in sen_cmd.
REQ-013 SHALL have port sen_cmd_flag, output, 1 bit: one-cycle valid pulse for sen_cmd.
REQ-014 SHALL have port err_flag, output, 1 bit: one-cycle pulse for a rejected frame.
REQ-015 SHALL have port err_code, output, 2 bits: 1 = CRC, 2 = length, 3 = timeout; held until the next err_flag.

Function
REQ-016 SHALL parse this frame, bytes in order: ADDR_H, ADDR_L, LEN_H, LEN_L, then LEN body bytes (SID, RW, data[0..LEN-3]), then CRC_L, CRC_H.
REQ-017 SHALL implement states S_IDLE, S_ADDR_L, S_LEN_H, S_LEN_L, S_SID, S_RW, S_DATA, S_CRC_L, S_CRC_H, S_SKIP; a state advances only in a cycle where rx_flag=1.
REQ-018 SHALL compute CRC-16/MODBUS (init 16'hFFFF, reflected polynomial 16'hA001) over every byte from ADDR_H through the last body byte, one byte per rx_flag, with zero-cycle byte latency.
REQ-019 SHALL, on LEN_L, go to S_SKIP if {ADDR_H, ADDR_L} != DEV_ID.
REQ-020 SHALL load a 17-bit skip counter with LEN+2 in that case.
REQ-021 SHALL decrement the skip counter on each rx_flag and return to S_IDLE on the byte that makes it zero.
REQ-022 SHALL raise no error for an address mismatch.
REQ-023 SHALL, on LEN_L with a matching address and (LEN < 2 or LEN-2 > DATA_BYTES), skip LEN+2 bytes and pulse err_flag with code 2 on the byte that makes the skip counter zero.
REQ-024 SHALL, in S_RW, go to S_DATA when LEN > 2, otherwise go to S_CRC_L.
REQ-025 SHALL, in S_DATA, store byte i at data[8i+7:8i] and leave to S_CRC_L after LEN-2 bytes.
REQ-026 SHALL zero all unused data bytes at S_SID.
REQ-027 SHALL, on the rx_flag cycle N that carries CRC_H, compare {CRC_H, CRC_L} with the computed CRC.
REQ-028 SHALL, on a CRC match with a read (RW == READ_CODE), drive ret_cmd = SID with ret_cmd_flg = 1 in cycle N+1 only.
REQ-029 SHALL, on a CRC match with a write, drive sen_cmd, sen_cmd_len = LEN-2 and sen_cmd_flag = 1 in cycle N+1 only.
REQ-030 SHALL accept a read frame whose LEN > 2 and discard its data bytes.
REQ-031 SHALL, on a CRC mismatch, pulse err_flag with code 1 in N+1 and emit no command.
REQ-032 SHALL return to S_IDLE at N+1; an ADDR_H strobed at N+1 is accepted (back-to-back frames).
REQ-033 SHALL hold ret_cmd, sen_cmd and sen_cmd_len at their last values between pulses.
REQ-034 SHALL count clocks without rx_flag in any state except S_IDLE.
REQ-035 SHALL, when that count reaches TIMEOUT_CYC, enter S_IDLE, discard the frame and pulse err_flag with code 3.
REQ-036 SHALL let a byte arriving in the same cycle as the timeout win; no timeout is taken.
REQ-037 SHALL never assert ret_cmd_flg, sen_cmd_flag and err_flag in the same cycle.

Reset
REQ-038 SHALL, while sys_rst=1 at a clock edge, set the state to S_IDLE.
REQ-039 SHALL, in that case, clear all counters and the CRC register.
REQ-040 SHALL, in that case, drive all outputs to 0.
REQ-041 SHALL, on reset mid-frame, drop the partial frame silently, with no err_flag.
REQ-042 SHALL ignore rx_flag in a reset cycle.

Verification
REQ-043 SHALL cover a read: 00 01 00 02 05 03 + valid CRC -> ret_cmd=8'h05, ret_cmd_flg high exactly one cycle after CRC_H, no other flag.
REQ-044 SHALL cover a write: 00 01 00 06 07 00 AA BB CC DD + valid CRC -> sen_cmd={8'h07, 32'hDDCCBBAA}, sen_cmd_len=4, one-cycle sen_cmd_flag.
REQ-045 SHALL cover a short write and back-to-back frames: LEN=3 write with data 8'h11, then the read frame of REQ-043 starting the cycle after -> sen_cmd={8'h07, 32'h00000011}, len=1, then ret_cmd pulse.
REQ-046 SHALL cover a foreign address: 00 02 00 03 + 5 bytes -> no flags; the following valid read frame is decoded normally.
REQ-047 SHALL cover a bad CRC: the REQ-043 frame with CRC_L flipped -> err_flag with err_code=1, no command; LEN=8 with DATA_BYTES=4 -> err_code=2 after 10 skipped bytes.
REQ-048 SHALL cover timeout and reset: stop after LEN_H for TIMEOUT_CYC clocks -> err_code=3, then a valid frame decodes; sys_rst pulsed mid-body -> no flags, outputs 0.

Source files
------------

// File: rtl/rx_frame_parser.sv
// Receive-side frame parser: checks the bus address and length, runs a
// CRC-16/MODBUS over header and body, and turns good frames into a read-back
// request or a sensor write command. Bad frames raise a one-cycle error pulse.
module rx_frame_parser #(
    parameter logic [15:0] DEV_ID      = 16'h0001,
    parameter int          DATA_BYTES  = 4,
    parameter int          TIMEOUT_CYC = 10000,
    parameter logic [7:0]  READ_CODE   = 8'h03
) (
    input  logic                      sys_clk,
    input  logic                      sys_rst,
    input  logic                      rx_flag,
    input  logic [7:0]                rx_data,
    output logic [7:0]                ret_cmd,
    output logic                      ret_cmd_flg,
    output logic [8+8*DATA_BYTES-1:0] sen_cmd,
    output logic [4:0]                sen_cmd_len,
    output logic                      sen_cmd_flag,
    output logic                      err_flag,
    output logic [1:0]                err_code
);

    localparam int DW = 8 * DATA_BYTES;
    // The idle counter only has to reach TIMEOUT_CYC-1; the next quiet clock is the timeout.
    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [15:0]   MAX_LEN = 16'(DATA_BYTES + 2);

    localparam logic [1:0] ERR_CRC     = 2'd1;
    localparam logic [1:0] ERR_LEN     = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    typedef enum logic [3:0] {
        S_IDLE,
        S_ADDR_L,
        S_LEN_H,
        S_LEN_L,
        S_SID,
        S_RW,
        S_DATA,
        S_CRC_L,
        S_CRC_H,
        S_SKIP
    } state_t;

    state_t          state;
    state_t          state_next;

    logic [7:0]      addr_h;
    logic [7:0]      addr_l;
    logic [7:0]      len_h;
    logic [7:0]      sid;
    logic [7:0]      rw;
    logic [7:0]      crc_l;
    logic [15:0]     crc;
    logic [4:0]      payload_len;
    logic [4:0]      data_cnt;
    logic [DW-1:0]   frame_data;
    logic [16:0]     skip_cnt;
    logic            skip_err;
    logic [TW-1:0]   idle_cnt;

    logic [15:0]     frame_len;
    logic            addr_match;
    logic            len_bad;
    logic            timeout;
    logic [15:0]     crc_upd;
    logic            crc_ok;
    logic            skip_last;

    logic            do_read;
    logic            do_write;
    logic            do_err;
    logic [1:0]      err_code_next;

    // One byte of CRC-16/MODBUS, LSB first with the reflected polynomial.
    function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] r;
        r = c ^ {8'h00, b};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ 16'hA001) : (r >> 1);
        end
        return r;
    endfunction

    assign frame_len  = {len_h, rx_data};
    assign addr_match = ({addr_h, addr_l} == DEV_ID);
    assign len_bad    = (frame_len < 16'd2) || (frame_len > MAX_LEN);
    assign timeout    = (state != S_IDLE) && !rx_flag && (idle_cnt == TO_LAST);
    assign crc_upd    = crc_byte((state == S_IDLE) ? 16'hFFFF : crc, rx_data);
    assign crc_ok     = ({rx_data, crc_l} == crc);
    assign skip_last  = (skip_cnt == 17'd1);

    // State register; reset always lands in idle and drops any partial frame.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode: moves only on a received byte, except for the timeout exit.
    always_comb begin
        state_next = state;
        if (timeout) begin
            state_next = S_IDLE;
        end else if (rx_flag) begin
            case (state)
                S_IDLE:   state_next = S_ADDR_L;
                S_ADDR_L: state_next = S_LEN_H;
                S_LEN_H:  state_next = S_LEN_L;
                S_LEN_L:  state_next = (!addr_match || len_bad) ? S_SKIP : S_SID;
                S_SID:    state_next = S_RW;
                S_RW:     state_next = (payload_len != 5'd0) ? S_DATA : S_CRC_L;
                S_DATA:   state_next = ((data_cnt + 5'd1) == payload_len) ? S_CRC_L : S_DATA;
                S_CRC_L:  state_next = S_CRC_H;
                S_CRC_H:  state_next = S_IDLE;
                S_SKIP:   state_next = skip_last ? S_IDLE : S_SKIP;
                default:  state_next = S_IDLE;
            endcase
        end
    end

    // Output decode: which pulse (if any) the next cycle carries; the cases are mutually exclusive.
    always_comb begin
        do_read       = 1'b0;
        do_write      = 1'b0;
        do_err        = 1'b0;
        err_code_next = 2'd0;
        if (timeout) begin
            do_err        = 1'b1;
            err_code_next = ERR_TIMEOUT;
        end else if (rx_flag && (state == S_CRC_H)) begin
            if (!crc_ok) begin
                do_err        = 1'b1;
                err_code_next = ERR_CRC;
            end else if (rw == READ_CODE) begin
                do_read = 1'b1;
            end else begin
                do_write = 1'b1;
            end
        end else if (rx_flag && (state == S_SKIP) && skip_last && skip_err) begin
            do_err        = 1'b1;
            err_code_next = ERR_LEN;
        end
    end

    // Frame datapath: captures header/body fields, runs the CRC and the skip/idle counters.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            addr_h      <= 8'h00;
            addr_l      <= 8'h00;
            len_h       <= 8'h00;
            sid         <= 8'h00;
            rw          <= 8'h00;
            crc_l       <= 8'h00;
            crc         <= 16'h0000;
            payload_len <= 5'd0;
            data_cnt    <= 5'd0;
            frame_data  <= '0;
            skip_cnt    <= 17'd0;
            skip_err    <= 1'b0;
            idle_cnt    <= '0;
        end else begin
            if ((state == S_IDLE) || rx_flag || timeout) begin
                idle_cnt <= '0;
            end else begin
                idle_cnt <= idle_cnt + 1'b1;
            end

            if (rx_flag) begin
                case (state)
                    S_IDLE: begin
                        addr_h <= rx_data;
                        crc    <= crc_upd;
                    end
                    S_ADDR_L: begin
                        addr_l <= rx_data;
                        crc    <= crc_upd;
                    end
                    S_LEN_H: begin
                        len_h <= rx_data;
                        crc   <= crc_upd;
                    end
                    S_LEN_L: begin
                        crc         <= crc_upd;
                        payload_len <= frame_len[4:0] - 5'd2;
                        data_cnt    <= 5'd0;
                        skip_cnt    <= {1'b0, frame_len} + 17'd2;
                        skip_err    <= addr_match;
                    end
                    S_SID: begin
                        sid        <= rx_data;
                        crc        <= crc_upd;
                        frame_data <= '0;
                        data_cnt   <= 5'd0;
                    end
                    S_RW: begin
                        rw  <= rx_data;
                        crc <= crc_upd;
                    end
                    S_DATA: begin
                        crc <= crc_upd;
                        for (int i = 0; i < DATA_BYTES; i++) begin
                            if (data_cnt == 5'(i)) begin
                                frame_data[8*i +: 8] <= rx_data;
                            end
                        end
                        data_cnt <= data_cnt + 5'd1;
                    end
                    S_CRC_L: begin
                        crc_l <= rx_data;
                    end
                    S_SKIP: begin
                        skip_cnt <= skip_cnt - 17'd1;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    // Registered outputs: flags pulse for one cycle, payload and error code hold between pulses.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            ret_cmd      <= 8'h00;
            ret_cmd_flg  <= 1'b0;
            sen_cmd      <= '0;
            sen_cmd_len  <= 5'd0;
            sen_cmd_flag <= 1'b0;
            err_flag     <= 1'b0;
            err_code     <= 2'd0;
        end else begin
            ret_cmd_flg  <= do_read;
            sen_cmd_flag <= do_write;
            err_flag     <= do_err;
            if (do_read) begin
                ret_cmd <= sid;
            end
            if (do_write) begin
                sen_cmd     <= {sid, frame_data};
                sen_cmd_len <= payload_len;
            end
            if (do_err) begin
                err_code <= err_code_next;
            end
        end
    end

endmodule

// File: tb/tb_rx_frame_parser.sv
// Self-checking bench for rx_frame_parser: a table of directed frames with
// literal expectations, hand-written timeout/reset sequences, and random
// frames checked against a frame-level reference model.
module tb_rx_frame_parser;

    localparam logic [15:0] DEV = 16'h0001;
    localparam int          DB  = 4;
    localparam int          TO  = 10000;
    localparam logic [7:0]  RD  = 8'h03;
    localparam int          SW  = 8 + 8 * DB;

    logic          sys_clk = 1'b0;
    logic          sys_rst;
    logic          rx_flag;
    logic [7:0]    rx_data;
    logic [7:0]    ret_cmd;
    logic          ret_cmd_flg;
    logic [SW-1:0] sen_cmd;
    logic [4:0]    sen_cmd_len;
    logic          sen_cmd_flag;
    logic          err_flag;
    logic [1:0]    err_code;

    rx_frame_parser #(
        .DEV_ID      (DEV),
        .DATA_BYTES  (DB),
        .TIMEOUT_CYC (TO),
        .READ_CODE   (RD)
    ) dut (
        .sys_clk      (sys_clk),
        .sys_rst      (sys_rst),
        .rx_flag      (rx_flag),
        .rx_data      (rx_data),
        .ret_cmd      (ret_cmd),
        .ret_cmd_flg  (ret_cmd_flg),
        .sen_cmd      (sen_cmd),
        .sen_cmd_len  (sen_cmd_len),
        .sen_cmd_flag (sen_cmd_flag),
        .err_flag     (err_flag),
        .err_code     (err_code)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic [127:0]  raw;
        int            n;
        bit            addCrc;
        logic [15:0]   crcXor;
        int            preIdle;
        logic [2:0]    expFlags;
        logic [7:0]    expRet;
        logic [SW-1:0] expSen;
        logic [4:0]    expLen;
        logic [1:0]    expCode;
    } vec_t;

    vec_t          vecs[$];
    logic [7:0]    frameQ[$];
    logic [15:0]   crcTab[256];

    int vectors     = 0;
    int miscompares = 0;
    int pulseCnt    = 0;
    int expPulses   = 0;

    // Expected output state: pulse flags {ret, sen, err} for the cycle after a frame, plus held values.
    logic [2:0]    mFlags;
    logic [7:0]    mRet;
    logic [SW-1:0] mSen;
    logic [4:0]    mLen;
    logic [1:0]    mCode;

    // Counts every pulse and flags any cycle where more than one pulse is high.
    always @(negedge sys_clk) begin
        int s;
        s = int'(ret_cmd_flg) + int'(sen_cmd_flag) + int'(err_flag);
        if (s > 1) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL pulse_exclusive: got %0d pulses in one cycle, expected at most 1", s);
        end
        pulseCnt += s;
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic checkAll(input string tag, input logic [2:0] f, input logic [7:0] r,
                            input logic [SW-1:0] s, input logic [4:0] l, input logic [1:0] c);
        checkOutput($sformatf("%s.flags", tag), {61'd0, ret_cmd_flg, sen_cmd_flag, err_flag}, {61'd0, f});
        checkOutput($sformatf("%s.ret_cmd", tag), {56'd0, ret_cmd}, {56'd0, r});
        checkOutput($sformatf("%s.sen_cmd", tag), {24'd0, sen_cmd}, {24'd0, s});
        checkOutput($sformatf("%s.sen_cmd_len", tag), {59'd0, sen_cmd_len}, {59'd0, l});
        checkOutput($sformatf("%s.err_code", tag), {62'd0, err_code}, {62'd0, c});
    endtask

    task automatic checkModel(input string tag);
        checkAll(tag, mFlags, mRet, mSen, mLen, mCode);
    endtask

    // Byte-wise lookup table for CRC-16/MODBUS.
    task automatic buildCrcTable();
        for (int v = 0; v < 256; v++) begin
            logic [15:0] c;
            c = 16'(v);
            for (int k = 0; k < 8; k++) begin
                c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
            end
            crcTab[v] = c;
        end
    endtask

    function automatic logic [15:0] frameCrc(input int n);
        logic [15:0] c;
        c = 16'hFFFF;
        for (int i = 0; i < n; i++) begin
            c = (c >> 8) ^ crcTab[c[7:0] ^ frameQ[i]];
        end
        return c;
    endfunction

    task automatic loadRaw(input logic [127:0] raw, input int n, input bit addCrc, input logic [15:0] crcXor);
        logic [15:0] c;
        frameQ.delete();
        for (int i = 0; i < n; i++) begin
            frameQ.push_back(raw[8*(n-1-i) +: 8]);
        end
        if (addCrc) begin
            c = frameCrc(n) ^ crcXor;
            frameQ.push_back(c[7:0]);
            frameQ.push_back(c[15:8]);
        end
    endtask

    // Frame-level reference: decides the outcome from address, length and CRC of the whole frame.
    task automatic modelFrame();
        logic [15:0] addr;
        logic [15:0] len;
        logic [15:0] rxCrc;
        int          ln;
        addr   = {frameQ[0], frameQ[1]};
        len    = {frameQ[2], frameQ[3]};
        ln     = int'(len);
        mFlags = 3'b000;
        if (addr != DEV) begin
            mFlags = 3'b000;
        end else if (ln < 2 || ln - 2 > DB) begin
            mFlags = 3'b001;
            mCode  = 2'd2;
        end else begin
            rxCrc = {frameQ[ln+5], frameQ[ln+4]};
            if (rxCrc != frameCrc(ln + 4)) begin
                mFlags = 3'b001;
                mCode  = 2'd1;
            end else if (frameQ[5] == RD) begin
                mFlags = 3'b100;
                mRet   = frameQ[4];
            end else begin
                mFlags = 3'b010;
                mSen   = '0;
                mSen[SW-1 -: 8] = frameQ[4];
                for (int i = 0; i < ln - 2; i++) begin
                    mSen[8*i +: 8] = frameQ[6+i];
                end
                mLen = 5'(ln - 2);
            end
        end
        if (mFlags != 3'b000) expPulses++;
    endtask

    // Returns one cycle after the last byte's strobe, i.e. in the cycle the result pulse shows.
    task automatic sendBytes(input int first, input int last, input int maxGap);
        for (int i = first; i <= last; i++) begin
            int gap;
            gap = (maxGap > 0) ? int'($urandom_range(0, maxGap)) : 0;
            repeat (gap) begin
                @(posedge sys_clk);
                #1;
            end
            rx_flag = 1'b1;
            rx_data = frameQ[i];
            @(posedge sys_clk);
            #1;
            rx_flag = 1'b0;
            rx_data = 8'($urandom);
        end
    endtask

    task automatic idleCycles(input int n);
        repeat (n) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input vec_t v, input int idx);
        idleCycles(v.preIdle);
        loadRaw(v.raw, v.n, v.addCrc, v.crcXor);
        sendBytes(0, frameQ.size() - 1, 0);
        if (v.expFlags != 3'b000) expPulses++;
        checkAll($sformatf("vec%0d", idx), v.expFlags, v.expRet, v.expSen, v.expLen, v.expCode);
        mRet  = v.expRet;
        mSen  = v.expSen;
        mLen  = v.expLen;
        mCode = v.expCode;
    endtask

    task automatic addVec(input logic [127:0] raw, input int n, input bit addCrc, input logic [15:0] crcXor,
                          input int preIdle, input logic [2:0] f, input logic [7:0] r,
                          input logic [SW-1:0] s, input logic [4:0] l, input logic [1:0] c);
        vec_t v;
        v.raw = raw; v.n = n; v.addCrc = addCrc; v.crcXor = crcXor; v.preIdle = preIdle;
        v.expFlags = f; v.expRet = r; v.expSen = s; v.expLen = l; v.expCode = c;
        vecs.push_back(v);
    endtask

    task automatic buildRandom();
        int          sel;
        int          len;
        int          badLens[5];
        logic [15:0] addr;
        logic [15:0] c;
        logic [7:0]  b;
        badLens = '{0, 1, 7, 8, 9};
        sel  = int'($urandom_range(0, 9));
        addr = DEV;
        len  = int'($urandom_range(2, DB + 2));
        if (sel == 0) addr = 16'($urandom_range(2, 16'hFFFF));
        if (sel == 1) len = badLens[$urandom_range(0, 4)];
        frameQ.delete();
        frameQ.push_back(addr[15:8]);
        frameQ.push_back(addr[7:0]);
        frameQ.push_back(8'h00);
        frameQ.push_back(8'(len));
        for (int i = 0; i < len; i++) begin
            b = 8'($urandom);
            if (i == 1 && $urandom_range(0, 1) == 1) b = RD;
            frameQ.push_back(b);
        end
        c = frameCrc(4 + len);
        if (sel == 2) c = c ^ 16'($urandom_range(1, 16'hFFFF));
        frameQ.push_back(c[7:0]);
        frameQ.push_back(c[15:8]);
    endtask

    initial begin
        buildCrcTable();

        //     raw bytes (MSB first)                       n  crc xor     pre  flags   ret    sen_cmd             len  code
        addVec(128'h0001_0002_0503,                        6, 1, 16'h0000, 0, 3'b100, 8'h05, 40'h00_00000000, 5'd0, 2'd0);
        addVec(128'h0001_0006_0700_AABB_CCDD,             10, 1, 16'h0000, 0, 3'b010, 8'h05, 40'h07_DDCCBBAA, 5'd4, 2'd0);
        addVec(128'h0001_0003_0700_11,                     7, 1, 16'h0000, 0, 3'b010, 8'h05, 40'h07_00000011, 5'd1, 2'd0);
        addVec(128'h0001_0002_0503,                        6, 1, 16'h0000, 0, 3'b100, 8'h05, 40'h07_00000011, 5'd1, 2'd0);
        addVec(128'h0002_0003_1122_3344_55,                9, 0, 16'h0000, 0, 3'b000, 8'h05, 40'h07_00000011, 5'd1, 2'd0);
        addVec(128'h0001_0002_0903,                        6, 1, 16'h0000, 0, 3'b100, 8'h09, 40'h07_00000011, 5'd1, 2'd0);
        addVec(128'h0001_0002_0503,                        6, 1, 16'h00FF, 0, 3'b001, 8'h09, 40'h07_00000011, 5'd1, 2'd1);
        addVec(128'h0001_0008_0102_0304_0506_0708_090A,    14, 0, 16'h0000, 0, 3'b001, 8'h09, 40'h07_00000011, 5'd1, 2'd2);
        addVec(128'h0001_0004_0A03_EEFF,                   8, 1, 16'h0000, 0, 3'b100, 8'h0A, 40'h07_00000011, 5'd1, 2'd2);
        addVec(128'h0001_0002_2201,                        6, 1, 16'h0000, 0, 3'b010, 8'h0A, 40'h22_00000000, 5'd0, 2'd2);
        addVec(128'h0001_0000_ABCD,                        6, 0, 16'h0000, 0, 3'b001, 8'h0A, 40'h22_00000000, 5'd0, 2'd2);
        addVec(128'h0001_0006_3C04_0102_0304,             10, 1, 16'h0000, 0, 3'b010, 8'h0A, 40'h3C_04030201, 5'd4, 2'd2);
        addVec(128'h0001_0002_7E03,                        6, 1, 16'h0000, 3, 3'b100, 8'h7E, 40'h3C_04030201, 5'd4, 2'd2);
        addVec(128'h1234_0000_5678,                        6, 0, 16'h0000, 0, 3'b000, 8'h7E, 40'h3C_04030201, 5'd4, 2'd2);
        addVec(128'h0100_0003_0102_0304_05,                9, 0, 16'h0000, 0, 3'b000, 8'h7E, 40'h3C_04030201, 5'd4, 2'd2);

        // Reset with a strobe present: the strobe must be ignored and all outputs clear.
        sys_rst = 1'b1;
        rx_flag = 1'b1;
        rx_data = 8'h00;
        repeat (3) @(posedge sys_clk);
        #1;
        sys_rst = 1'b0;
        rx_flag = 1'b0;
        mRet = 8'h00; mSen = '0; mLen = 5'd0; mCode = 2'd0; mFlags = 3'b000;
        checkAll("reset", 3'b000, 8'h00, '0, 5'd0, 2'd0);

        $display("[TB] directed table");
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i], i);
        end

        $display("[TB] timeout after LEN_H");
        idleCycles(2);
        loadRaw(128'h0001_0002_4403, 6, 1, 16'h0000);
        sendBytes(0, 2, 0);
        for (int k = 1; k <= TO; k++) begin
            @(posedge sys_clk);
            #1;
            if (k == TO - 1) checkOutput("timeout_early", {63'd0, err_flag}, 64'd0);
        end
        mCode = 2'd3;
        expPulses++;
        checkAll("timeout", 3'b001, mRet, mSen, mLen, mCode);
        modelFrame();
        sendBytes(0, frameQ.size() - 1, 0);
        checkModel("after_timeout");

        $display("[TB] byte arriving on the timeout cycle");
        idleCycles(2);
        loadRaw(128'h0001_0002_5503, 6, 1, 16'h0000);
        modelFrame();
        sendBytes(0, 1, 0);
        idleCycles(TO - 1);
        sendBytes(2, frameQ.size() - 1, 0);
        checkModel("byte_wins");

        $display("[TB] reset mid-body");
        idleCycles(2);
        loadRaw(128'h0001_0006_0700_AABB_CCDD, 10, 1, 16'h0000);
        sendBytes(0, 6, 0);
        sys_rst = 1'b1;
        rx_flag = 1'b1;
        rx_data = 8'h00;
        @(posedge sys_clk);
        #1;
        sys_rst = 1'b0;
        rx_flag = 1'b0;
        mRet = 8'h00; mSen = '0; mLen = 5'd0; mCode = 2'd0;
        checkAll("rst_mid", 3'b000, 8'h00, '0, 5'd0, 2'd0);
        idleCycles(1);
        checkOutput("rst_noerr", {63'd0, err_flag}, 64'd0);
        loadRaw(128'h0001_0002_0503, 6, 1, 16'h0000);
        modelFrame();
        sendBytes(0, frameQ.size() - 1, 0);
        checkModel("after_rst");

        $display("[TB] random frames");
        for (int i = 0; i < 40; i++) begin
            buildRandom();
            modelFrame();
            idleCycles(int'($urandom_range(0, 2)));
            sendBytes(0, frameQ.size() - 1, 2);
            checkModel($sformatf("rand%0d", i));
        end

        idleCycles(3);
        checkOutput("pulse_total", 64'(pulseCnt), 64'(expPulses));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
